rand_share_arbiter: RTL and testbench
=====================================

# rand_share_arbiter

Round-robin scheduler that shares the single RangeLFSR16 random-range generator among NUM_REQ game requesters (fish spawn delay, fish lane, bite window). It sequences the generator's Restart and Run controls, muxes the winning requester's offset/limit onto it, and returns one sampled value per grant with a one-cycle ack. It sits between the game-control FSMs and the RangeLFSR16 instance.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- WIDTH, 16, data width of offset, limit and value
- MIX_CYCLES, 4, Run cycles per draw (≥1)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request; held until matching ack
- offset_bus  in  NUM_REQ*WIDTH  per-requester lower bound; requester i at [i*WIDTH +: WIDTH]
- limit_bus  in  NUM_REQ*WIDTH  per-requester upper bound, same packing
- ack  out  NUM_REQ  one-hot, one-cycle pulse: draw complete
- err  out  1  pulses with ack when the serviced request had limit < offset
- rand_out  out  WIDTH  drawn value, valid while ack high, held until next ack
- lfsr_restart  out  1  to RangeLFSR16 Restart
- lfsr_run  out  1  to RangeLFSR16 Run
- lfsr_offset  out  WIDTH  to RangeLFSR16 offset
- lfsr_limit  out  WIDTH  to RangeLFSR16 limit
- lfsr_out  in  WIDTH  from RangeLFSR16 out

## Operation
- Reset (RST=0, any time, including mid-draw): state INIT; ack=0, err=0, rand_out=0, lfsr_run=0, lfsr_restart=1, lfsr_offset=0, lfsr_limit=0, rr pointer=0.
- INIT: lfsr_restart=1 for exactly one cycle after reset release → IDLE.
- IDLE: if any unmasked req, pick winner round-robin starting at pointer; latch winner index, its offset and limit; → LOAD. Requester whose ack is high this cycle is masked.
- LOAD: lfsr_offset/lfsr_limit driven from latches (held constant until next LOAD); lfsr_run=0. If limit < offset → SAMPLE with error flag set; else → MIX.
- MIX: lfsr_run=1 for MIX_CYCLES consecutive cycles (down-counter), → SAMPLE.
- SAMPLE: lfsr_run=0 for one cycle; at its closing edge rand_out ← lfsr_out (or latched offset on error), ack ← onehot(winner), err ← error flag; pointer ← winner+1 mod NUM_REQ; → IDLE.
- Latched offset/limit isolate the draw from bus changes after IDLE.
- Req dropped mid-draw: draw completes, ack still pulses, pointer still advances.
- Generator not restarted between draws; sequence continues across requesters.

## Timing
- Req high in IDLE at cycle 0 → LOAD 1 → MIX 2..MIX_CYCLES+1 → SAMPLE MIX_CYCLES+2 → ack high in cycle MIX_CYCLES+3 (7 with default).
- Error path: ack+err in cycle 3; lfsr_run never asserted.
- Requester must deassert req in the cycle after ack; sustained throughput one draw per MIX_CYCLES+3 cycles.
- Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ−1 draws.
- All outputs registered except lfsr_restart/lfsr_run (state decode, glitch-free one-hot state).

## Structure
- Shared package: state encoding (INIT, IDLE, LOAD, MIX, SAMPLE), default WIDTH, MIX_CYCLES.
- Sub-module rr_arbiter: combinational round-robin pick (req & ~mask, pointer) → one-hot grant plus index; reusable by other shared game resources.

## Test plan
- Reset release with no req → lfsr_restart high exactly 1 cycle, then IDLE; all other outputs 0.
- req[0] with offset 20, limit 25 → lfsr_run high 4 cycles, ack[0] in cycle 7, rand_out in [20,25].
- req=3'b111 held, each dropping after its ack → acks in order 0,1,2 at cycles 7,14,21; each rand_out within own range.
- req[1] with offset 30, limit 10 → ack[1] and err in cycle 3, rand_out=30, lfsr_run never high.
- Change offset_bus during MIX → lfsr_offset unchanged, result within originally latched range.
- RST low during MIX → outputs return to reset values immediately; after release INIT restart pulse, pending req re-serviced fresh.

Source files
------------

// File: rtl/rand_share_arbiter_pkg.sv
// Shared definitions for the random-range generator arbiter: FSM encoding,
// default sizing and a small index-width helper.
package rand_share_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ    = 3;
  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_MIX_CYCLES = 4;

  // One-hot so the generator controls decode from a single flop bit.
  typedef enum logic [4:0] {
    ST_INIT   = 5'b00001,
    ST_IDLE   = 5'b00010,
    ST_LOAD   = 5'b00100,
    ST_MIX    = 5'b01000,
    ST_SAMPLE = 5'b10000
  } state_e;

  localparam int ST_INIT_BIT = 0;
  localparam int ST_MIX_BIT  = 3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rand_share_arbiter_if.sv
// Requester-side and generator-side signals of the shared random arbiter.
// The arbiter connects through the slave modport.
interface rand_share_arbiter_if
  import rand_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] offset_bus;
  logic [NUM_REQ*WIDTH-1:0] limit_bus;
  logic [NUM_REQ-1:0]       ack;
  logic                     err;
  logic [WIDTH-1:0]         rand_out;

  logic                     lfsr_restart;
  logic                     lfsr_run;
  logic [WIDTH-1:0]         lfsr_offset;
  logic [WIDTH-1:0]         lfsr_limit;
  logic [WIDTH-1:0]         lfsr_out;

  modport master (
    output req, offset_bus, limit_bus, lfsr_out,
    input  ack, err, rand_out, lfsr_restart, lfsr_run, lfsr_offset, lfsr_limit
  );

  modport slave (
    input  req, offset_bus, limit_bus, lfsr_out,
    output ack, err, rand_out, lfsr_restart, lfsr_run, lfsr_offset, lfsr_limit
  );

endinterface

// File: rtl/rand_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after the
// pointer, wrapping, returned as one-hot grant plus binary index.
module rr_arbiter
  import rand_share_arbiter_pkg::*;
#(
  parameter  int N  = DEFAULT_NUM_REQ,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0] eligible;
  logic [IW:0]  pos;

  assign eligible = req_i & ~mask_i;

  // One extra bit on pos so ptr + i never overflows before the wrap.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!valid_o && eligible[pos[IW-1:0]]) begin
        valid_o                = 1'b1;
        grant_o[pos[IW-1:0]]   = 1'b1;
        idx_o                  = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rand_share_arbiter.sv
// Shares one RangeLFSR16 among several requesters: round-robin grant, latch
// bounds, run the generator for a fixed number of cycles, return one sample.
module rand_share_arbiter
  import rand_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MIX_CYCLES = DEFAULT_MIX_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rand_share_arbiter_if.slave  arb_if
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = idx_width(MIX_CYCLES);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      winner_q, winner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [WIDTH-1:0]   off_q, off_d;
  logic [WIDTH-1:0]   lim_q, lim_d;
  logic [WIDTH-1:0]   rand_q, rand_d;
  logic               err_flag_q, err_flag_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_valid;
  logic [WIDTH-1:0]   sel_offset;
  logic [WIDTH-1:0]   sel_limit;

  // The requester being acked this cycle is masked so its still-high req
  // cannot win a second draw before it has had a chance to drop.
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (arb_if.req),
    .mask_i  (ack_q),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_valid)
  );

  always_comb begin
    sel_offset = '0;
    sel_limit  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_offset = arb_if.offset_bus[i*WIDTH +: WIDTH];
        sel_limit  = arb_if.limit_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    off_d      = off_q;
    lim_d      = lim_q;
    err_flag_d = err_flag_q;
    rand_d     = rand_q;
    ack_d      = '0;
    err_d      = 1'b0;

    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (grant_valid) begin
          winner_d = grant_idx;
          off_d    = sel_offset;
          lim_d    = sel_limit;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        err_flag_d = (lim_q < off_q);
        cnt_d      = CW'(MIX_CYCLES - 1);
        state_d    = (lim_q < off_q) ? ST_SAMPLE : ST_MIX;
      end

      ST_MIX: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // An inverted range never runs the generator and returns the offset.
      ST_SAMPLE: begin
        rand_d  = err_flag_q ? off_q : arb_if.lfsr_out;
        ack_d   = NUM_REQ'(1) << winner_q;
        err_d   = err_flag_q;
        ptr_d   = (winner_q == IW'(NUM_REQ - 1)) ? '0 : winner_q + IW'(1);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      winner_q   <= '0;
      ptr_q      <= '0;
      off_q      <= '0;
      lim_q      <= '0;
      err_flag_q <= 1'b0;
      rand_q     <= '0;
      err_q      <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      winner_q   <= winner_d;
      ptr_q      <= ptr_d;
      off_q      <= off_d;
      lim_q      <= lim_d;
      err_flag_q <= err_flag_d;
      rand_q     <= rand_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
    end
  end

  // Generator controls come straight off single state flops.
  assign arb_if.lfsr_restart = state_q[ST_INIT_BIT];
  assign arb_if.lfsr_run     = state_q[ST_MIX_BIT];
  assign arb_if.lfsr_offset  = off_q;
  assign arb_if.lfsr_limit   = lim_q;
  assign arb_if.ack          = ack_q;
  assign arb_if.err          = err_q;
  assign arb_if.rand_out     = rand_q;

  a_ack_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ack_q));

  a_err_with_ack : assert property (@(posedge clk_i) disable iff (!rst_ni)
    err_q |-> (ack_q != '0));

endmodule

// File: tb/tb_rand_share_arbiter.sv
// Directed bench for rand_share_arbiter; the generator is stood in for by a
// bench-driven lfsr_out that changes every cycle so the sample edge is visible.
module tb_rand_share_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int WIDTH      = 16;
  localparam int MIX_CYCLES = 4;

  logic clk = 1'b0;
  logic rstN;

  int checkCount  = 0;
  int errorCount  = 0;
  int cyc         = 0;
  int genBase     = 0;
  int genRange    = 1;
  int runSeen     = 0;
  int restartSeen = 0;
  int extraAcks   = 0;
  logic [NUM_REQ-1:0] dropMask;

  int                 ackCyc;
  logic [NUM_REQ-1:0] ackVal;
  logic               errVal;
  logic [WIDTH-1:0]   randVal;
  logic               rangeOk;
  int                 rrLo [3] = '{10, 15, 12};
  int                 rrHi [3] = '{20, 25, 30};

  rand_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) busIf ();

  rand_share_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WIDTH      (WIDTH),
    .MIX_CYCLES (MIX_CYCLES)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .arb_if (busIf.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] genVal(input int c);
    if (c < 0) return WIDTH'(genBase);
    return WIDTH'(genBase + (c % genRange));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic setRange(input int idx, input int off, input int lim);
    busIf.offset_bus[idx*WIDTH +: WIDTH] = WIDTH'(off);
    busIf.limit_bus[idx*WIDTH +: WIDTH]  = WIDTH'(lim);
  endtask

  // Called just after an edge while the arbiter sits in IDLE: that is cycle 0.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] reqV);
    busIf.req      = reqV;
    cyc            = 0;
    runSeen        = 0;
    busIf.lfsr_out = genVal(0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    busIf.req      = busIf.req & ~dropMask;
    dropMask       = '0;
    busIf.lfsr_out = genVal(cyc);
    if (busIf.lfsr_run) runSeen++;
    if (busIf.lfsr_restart) restartSeen++;
  endtask

  task automatic waitAck(input int maxCyc, output int aCyc,
                         output logic [NUM_REQ-1:0] aVal, output logic eVal,
                         output logic [WIDTH-1:0] rVal);
    logic seen;
    seen = 1'b0;
    aCyc = -1;
    aVal = '0;
    eVal = 1'b0;
    rVal = '0;
    for (int n = 0; n < maxCyc; n++) begin
      tick();
      if (busIf.ack != '0) begin
        seen = 1'b1;
        aCyc = cyc;
        aVal = busIf.ack;
        eVal = busIf.err;
        rVal = busIf.rand_out;
        break;
      end
    end
    checkOutput("ack seen", 32'(seen), 32'd1);
  endtask

  initial begin
    rstN             = 1'b0;
    dropMask         = '0;
    busIf.req        = '0;
    busIf.offset_bus = '0;
    busIf.limit_bus  = '0;
    busIf.lfsr_out   = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst restart", 32'(busIf.lfsr_restart), 32'd1);
    checkOutput("rst run", 32'(busIf.lfsr_run), 32'd0);
    checkOutput("rst ack", 32'(busIf.ack), 32'd0);
    checkOutput("rst err", 32'(busIf.err), 32'd0);
    checkOutput("rst rand", 32'(busIf.rand_out), 32'd0);
    checkOutput("rst offset", 32'(busIf.lfsr_offset), 32'd0);
    checkOutput("rst limit", 32'(busIf.lfsr_limit), 32'd0);

    rstN        = 1'b1;
    restartSeen = busIf.lfsr_restart ? 1 : 0;
    runSeen     = 0;
    repeat (4) tick();
    checkOutput("init restart pulses", 32'(restartSeen), 32'd1);
    checkOutput("init run", 32'(runSeen), 32'd0);
    checkOutput("init ack", 32'(busIf.ack), 32'd0);

    // All three requesters at once; the shared window 15..19 fits every range.
    setRange(0, 10, 20);
    setRange(1, 15, 25);
    setRange(2, 12, 30);
    genBase  = 15;
    genRange = 5;
    applyStimulus(3'b111);
    for (int k = 0; k < 3; k++) begin
      waitAck(12, ackCyc, ackVal, errVal, randVal);
      checkOutput($sformatf("rr%0d ack", k), 32'(ackVal), 32'(1 << k));
      checkOutput($sformatf("rr%0d cycle", k), 32'(ackCyc), 32'(7 * (k + 1)));
      checkOutput($sformatf("rr%0d rand", k), 32'(randVal),
                  32'(15 + ((7 * (k + 1) - 1) % 5)));
      checkOutput($sformatf("rr%0d err", k), 32'(errVal), 32'd0);
      rangeOk = (int'(randVal) >= rrLo[k]) && (int'(randVal) <= rrHi[k]);
      checkOutput($sformatf("rr%0d in range", k), 32'(rangeOk), 32'd1);
      dropMask = ackVal;
    end
    checkOutput("rr run cycles", 32'(runSeen), 32'd12);
    extraAcks = 0;
    repeat (6) begin
      tick();
      if (busIf.ack != '0) extraAcks++;
    end
    checkOutput("rr no extra ack", 32'(extraAcks), 32'd0);

    setRange(0, 20, 25);
    genBase  = 20;
    genRange = 6;
    applyStimulus(3'b001);
    tick();
    checkOutput("single load offset", 32'(busIf.lfsr_offset), 32'd20);
    checkOutput("single load limit", 32'(busIf.lfsr_limit), 32'd25);
    checkOutput("single load run", 32'(busIf.lfsr_run), 32'd0);
    waitAck(12, ackCyc, ackVal, errVal, randVal);
    checkOutput("single ack", 32'(ackVal), 32'b001);
    checkOutput("single cycle", 32'(ackCyc), 32'd7);
    checkOutput("single rand", 32'(randVal), 32'd20);
    checkOutput("single err", 32'(errVal), 32'd0);
    checkOutput("single run cycles", 32'(runSeen), 32'(MIX_CYCLES));
    dropMask = ackVal;
    tick();
    checkOutput("single ack pulse", 32'(busIf.ack), 32'd0);
    checkOutput("single rand held", 32'(busIf.rand_out), 32'd20);

    // Inverted range returns the offset without running the generator.
    setRange(1, 30, 10);
    genBase  = 5;
    genRange = 3;
    applyStimulus(3'b010);
    waitAck(12, ackCyc, ackVal, errVal, randVal);
    checkOutput("error ack", 32'(ackVal), 32'b010);
    checkOutput("error cycle", 32'(ackCyc), 32'd3);
    checkOutput("error flag", 32'(errVal), 32'd1);
    checkOutput("error rand", 32'(randVal), 32'd30);
    checkOutput("error run cycles", 32'(runSeen), 32'd0);
    dropMask = ackVal;
    tick();
    checkOutput("error flag pulse", 32'(busIf.err), 32'd0);

    setRange(1, 40, 50);
    genBase  = 40;
    genRange = 11;
    applyStimulus(3'b010);
    repeat (3) tick();
    setRange(1, 100, 200);
    checkOutput("latch mix run", 32'(busIf.lfsr_run), 32'd1);
    tick();
    checkOutput("latch offset", 32'(busIf.lfsr_offset), 32'd40);
    checkOutput("latch limit", 32'(busIf.lfsr_limit), 32'd50);
    waitAck(12, ackCyc, ackVal, errVal, randVal);
    checkOutput("latch ack", 32'(ackVal), 32'b010);
    checkOutput("latch cycle", 32'(ackCyc), 32'd7);
    checkOutput("latch rand", 32'(randVal), 32'd46);
    dropMask = ackVal;
    tick();

    // Pointer sits at 2 here, so a 2'b11 request pair shows whether it reset.
    setRange(1, 20, 25);
    setRange(2, 20, 25);
    genBase  = 20;
    genRange = 6;
    applyStimulus(3'b110);
    repeat (3) tick();
    checkOutput("midreset run before", 32'(busIf.lfsr_run), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midreset run", 32'(busIf.lfsr_run), 32'd0);
    checkOutput("midreset restart", 32'(busIf.lfsr_restart), 32'd1);
    checkOutput("midreset ack", 32'(busIf.ack), 32'd0);
    checkOutput("midreset err", 32'(busIf.err), 32'd0);
    checkOutput("midreset rand", 32'(busIf.rand_out), 32'd0);
    checkOutput("midreset offset", 32'(busIf.lfsr_offset), 32'd0);
    checkOutput("midreset limit", 32'(busIf.lfsr_limit), 32'd0);
    repeat (2) tick();
    rstN        = 1'b1;
    cyc         = -1;
    restartSeen = busIf.lfsr_restart ? 1 : 0;
    runSeen     = 0;
    waitAck(14, ackCyc, ackVal, errVal, randVal);
    checkOutput("after reset ack", 32'(ackVal), 32'b010);
    checkOutput("after reset cycle", 32'(ackCyc), 32'd7);
    checkOutput("after reset rand", 32'(randVal), 32'd20);
    checkOutput("after reset restart", 32'(restartSeen), 32'd1);
    checkOutput("after reset run", 32'(runSeen), 32'(MIX_CYCLES));
    dropMask = ackVal;
    waitAck(12, ackCyc, ackVal, errVal, randVal);
    checkOutput("after reset ack2", 32'(ackVal), 32'b100);
    checkOutput("after reset cycle2", 32'(ackCyc), 32'd14);
    checkOutput("after reset rand2", 32'(randVal), 32'd21);
    dropMask = ackVal;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
